sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: cycles per 16-bit SRAM phase; legal range 1..15.
REQ-002 Parameter DATA_MEM_BASE, default 1024: byte address mapped to SRAM word 0.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 rd_en  input  1  MEM-stage read request.
REQ-006 wr_en  input  1  MEM-stage write request.
REQ-007 address  input  32  byte address of the access (ALU result).
REQ-008 write_data  input  32  store data (Rm value).
REQ-009 read_data  output  32  load data, registered.
REQ-010 ready  output  1  high when no request is pending or the current request has completed; low means the pipeline freezes.
REQ-011 sram_addr  output  18  SRAM half-word address.
REQ-012 sram_dq_out  output  16  write data to SRAM.
REQ-013 sram_dq_oe  output  1  drive enable for the SRAM data bus.
REQ-014 sram_dq_in  input  16  read data from SRAM.
REQ-015 sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-016 FSM states SHALL be IDLE, LO, HI, DONE.
REQ-017 IDLE -> LO when rd_en|wr_en; otherwise stay in IDLE; address, write_data and access type are latched on this edge.
REQ-018 LO and HI SHALL each last exactly WAIT_CYCLES cycles, timed by a 4-bit counter cleared on each phase entry.
REQ-019 LO -> HI, HI -> DONE, and DONE -> IDLE transitions are unconditional once the counter expires.
REQ-020 word = (latched address - DATA_MEM_BASE) >> 2, truncated to 17 bits (wraps modulo 2^17 with no error).
REQ-021 sram_addr SHALL be {word,0} in LO, {word,1} in HI, and 0 otherwise.
REQ-022 ready = ~(rd_en|wr_en) | (state==DONE), combinational.
REQ-023 A request seen in IDLE at cycle 0 SHALL give ready=1 in cycle 2*WAIT_CYCLES+1.
REQ-024 Write: sram_we_n=0 and sram_dq_oe=1 in every LO/HI cycle.
REQ-025 Write: sram_dq_out = write_data[15:0] in LO and write_data[31:16] in HI.
REQ-026 Write: sram_we_n=1, sram_dq_oe=0 and sram_dq_out=0 in every other state.
REQ-027 Read: sram_we_n=1 and sram_dq_oe=0 throughout.
REQ-028 Read: sram_dq_in is captured into read_data[15:0] on the last LO cycle and into read_data[31:16] on the last HI cycle.
REQ-029 read_data SHALL hold its value until overwritten by a later read; writes never change it.
REQ-030 rd_en and wr_en both high: the access is a write.
REQ-031 A request dropped mid-transaction SHALL still complete all SRAM phases; ready follows REQ-022.
REQ-032 DONE always returns to IDLE, so a request held high across DONE starts a new transaction.

Reset
REQ-033 When rst=0 at a clock edge: state=IDLE and counter=0.
REQ-034 Same edge: read_data=0, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0, sram_addr=0.
REQ-035 Reset during LO/HI SHALL abort the transaction with no further SRAM write strobes.
REQ-036 In the first cycle after reset release, ready = ~(rd_en|wr_en).

Structure
REQ-037 A shared package SHALL hold:
- state enum;
- SRAM_ADDR_W=18, SRAM_DATA_W=16;
- DATA_MEM_BASE default.
REQ-038 The RTL is a single module with no sub-modules.
REQ-039 The bench SHALL use a behavioural sub-module sram_model (256K x 16) that drives sram_dq_in combinationally from sram_addr.

Verification
REQ-040 WAIT_CYCLES=2: wr_en=1, address=1028, write_data=0xDEADBEEF -> ready=0 in cycles 0..4 and 1 in cycle 5.
REQ-041 Same write -> model half-word 2 = 0xBEEF and half-word 3 = 0xDEAD.
REQ-042 Then rd_en=1, address=1028 -> ready=1 in cycle 5 with read_data=0xDEADBEEF.
REQ-043 rd_en=1 and wr_en=1, address=1024, write_data=0x12345678 -> a write is performed; read_data is unchanged.
REQ-044 address=1024+4*2^17 -> wraps to word 0 (sram_addr 0 then 1).
REQ-045 rst=0 asserted in cycle 2 of a write -> next cycle shows state IDLE, sram_we_n=1, sram_dq_oe=0, read_data=0.
REQ-046 Back-to-back reads held high: a second transaction starts in the cycle after DONE.
REQ-047 Back-to-back reads held high: ready pulses for exactly one cycle per transaction.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// rtl/sram_controller_pkg.sv - shared types and constants for the SRAM controller
package sram_controller_pkg;

    localparam int          SRAM_ADDR_W           = 18;
    localparam int          SRAM_DATA_W           = 16;
    localparam logic [31:0] DEFAULT_DATA_MEM_BASE = 32'd1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - pipeline request bus and SRAM pin bundle
interface sram_controller_if
    import sram_controller_pkg::*;
;
    logic                   rd_en;
    logic                   wr_en;
    logic [31:0]            address;
    logic [31:0]            write_data;
    logic [31:0]            read_data;
    logic                   ready;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [SRAM_DATA_W-1:0] sram_dq_out;
    logic                   sram_dq_oe;
    logic [SRAM_DATA_W-1:0] sram_dq_in;
    logic                   sram_we_n;

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage access split into two 16-bit SRAM phases
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          WAIT_CYCLES   = 2,
    parameter logic [31:0] DATA_MEM_BASE = DEFAULT_DATA_MEM_BASE
) (
    input logic              clk,
    input logic              rst,
    sram_controller_if.slave bus
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [16:0] word;
    logic [31:0] wdata;
    logic        is_wr;
    logic [31:0] rdata;
    logic        req;
    logic        expire;
    logic [16:0] word_in;

    assign req     = bus.rd_en | bus.wr_en;
    assign expire  = (cnt == LAST_CNT);
    assign word_in = 17'((bus.address - DATA_MEM_BASE) >> 2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            word  <= 17'd0;
            wdata <= 32'd0;
            is_wr <= 1'b0;
            rdata <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && req) begin
                word  <= word_in;
                wdata <= bus.write_data;
                is_wr <= bus.wr_en;
            end
            // Capture on the final cycle of each phase, once the SRAM has settled.
            if (!is_wr && expire && state == LO) rdata[15:0]  <= bus.sram_dq_in;
            if (!is_wr && expire && state == HI) rdata[31:16] <= bus.sram_dq_in;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = 4'd0;
        case (state)
            IDLE: if (req) state_next = LO;
            LO: begin
                if (expire) state_next = HI;
                else        cnt_next   = cnt + 4'd1;
            end
            HI: begin
                if (expire) state_next = DONE;
                else        cnt_next   = cnt + 4'd1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_we_n   = 1'b1;
        bus.sram_dq_oe  = 1'b0;
        if (state == LO) begin
            bus.sram_addr = {word, 1'b0};
            if (is_wr) begin
                bus.sram_dq_out = wdata[15:0];
                bus.sram_we_n   = 1'b0;
                bus.sram_dq_oe  = 1'b1;
            end
        end else if (state == HI) begin
            bus.sram_addr = {word, 1'b1};
            if (is_wr) begin
                bus.sram_dq_out = wdata[31:16];
                bus.sram_we_n   = 1'b0;
                bus.sram_dq_oe  = 1'b1;
            end
        end
    end

    assign bus.ready     = ~req | (state == DONE);
    assign bus.read_data = rdata;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed self-checking bench with a behavioural 256K x 16 SRAM
module sram_model (
    input  logic        clk,
    input  logic [17:0] addr,
    input  logic [15:0] dq_out,
    input  logic        dq_oe,
    input  logic        we_n,
    output logic [15:0] dq_in
);
    logic [15:0] mem [0:262143];

    assign dq_in = mem[addr];

    always @(posedge clk) begin
        if (!we_n && dq_oe) mem[addr] <= dq_out;
    end
endmodule

module tb_sram_controller;
    import sram_controller_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    sram_controller_if bus ();

    sram_controller #(.WAIT_CYCLES(2), .DATA_MEM_BASE(32'd1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    sram_model u_mem (
        .clk    (clk),
        .addr   (bus.sram_addr),
        .dq_out (bus.sram_dq_out),
        .dq_oe  (bus.sram_dq_oe),
        .we_n   (bus.sram_we_n),
        .dq_in  (bus.sram_dq_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete transaction, cycle 0 = request seen in IDLE; ends in cycle 6 with request dropped.
    task automatic txn(input string tag, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [16:0] word);
        logic [17:0] ea;
        logic [15:0] ed;
        logic        ewe;
        @(posedge clk); #1;
        bus.rd_en = r; bus.wr_en = w; bus.address = a; bus.write_data = d;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ea  = (c == 1 || c == 2) ? {word, 1'b0} : (c == 3 || c == 4) ? {word, 1'b1} : 18'd0;
            ewe = !(w && c >= 1 && c <= 4);
            ed  = (w && (c == 1 || c == 2)) ? d[15:0] : (w && (c == 3 || c == 4)) ? d[31:16] : 16'h0;
            check($sformatf("%s_ready_c%0d", tag, c), 32'(bus.ready), 32'(c == 5));
            check($sformatf("%s_addr_c%0d", tag, c), 32'(bus.sram_addr), 32'(ea));
            check($sformatf("%s_we_n_c%0d", tag, c), 32'(bus.sram_we_n), 32'(ewe));
            check($sformatf("%s_oe_c%0d", tag, c), 32'(bus.sram_dq_oe), 32'(!ewe));
            check($sformatf("%s_dq_c%0d", tag, c), 32'(bus.sram_dq_out), 32'(ed));
        end
        @(posedge clk); #1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    endtask

    initial begin
        logic [13:0] rdy_mask;
        logic        we_ok;
        n_chk = 0;
        n_err = 0;
        rst = 1'b0;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        bus.address = 32'd0; bus.write_data = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_read_data", bus.read_data, 32'd0);
        check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        check("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
        check("rst_addr", 32'(bus.sram_addr), 32'd0);
        check("rst_dq", 32'(bus.sram_dq_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.ready), 32'd1);

        txn("wr1", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 17'd1);
        check("mem_hw2", 32'(u_mem.mem[2]), 32'h0000BEEF);
        check("mem_hw3", 32'(u_mem.mem[3]), 32'h0000DEAD);

        txn("rd1", 1'b1, 1'b0, 32'd1028, 32'h0, 17'd1);
        check("rd1_data", bus.read_data, 32'hDEADBEEF);

        txn("both", 1'b1, 1'b1, 32'd1024, 32'h12345678, 17'd0);
        check("both_read_data_held", bus.read_data, 32'hDEADBEEF);
        check("both_mem_hw0", 32'(u_mem.mem[0]), 32'h00005678);
        check("both_mem_hw1", 32'(u_mem.mem[1]), 32'h00001234);

        txn("rd0", 1'b1, 1'b0, 32'd1024, 32'h0, 17'd0);
        check("rd0_data", bus.read_data, 32'h12345678);

        txn("wrap_wr", 1'b0, 1'b1, 32'd525312, 32'hCAFEF00D, 17'd0);
        check("wrap_mem_hw0", 32'(u_mem.mem[0]), 32'h0000F00D);
        check("wrap_mem_hw1", 32'(u_mem.mem[1]), 32'h0000CAFE);
        txn("wrap_rd", 1'b1, 1'b0, 32'd525312, 32'h0, 17'd0);
        check("wrap_rd_data", bus.read_data, 32'hCAFEF00D);

        // Read held high: DONE at cycle 5, IDLE re-latches in 6, second DONE at 11.
        @(posedge clk); #1;
        bus.rd_en = 1'b1; bus.address = 32'd1028;
        rdy_mask = '0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            rdy_mask[c] = bus.ready;
            if (c == 6) check("b2b_addr_c6", 32'(bus.sram_addr), 32'd0);
            if (c == 7) check("b2b_addr_c7", 32'(bus.sram_addr), 32'd2);
        end
        check("b2b_ready_mask", 32'(rdy_mask), 32'h00000820);
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        repeat (8) @(posedge clk);
        check("b2b_read_data", bus.read_data, 32'hDEADBEEF);

        @(posedge clk); #1;
        bus.wr_en = 1'b1; bus.address = 32'd1032; bus.write_data = 32'hA5A55A5A;
        @(negedge clk);
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        @(negedge clk);
        check("drop_ready_c1", 32'(bus.ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("drop_we_n_c3", 32'(bus.sram_we_n), 32'd0);
        check("drop_addr_c3", 32'(bus.sram_addr), 32'd5);
        check("drop_dq_c3", 32'(bus.sram_dq_out), 32'h0000A5A5);
        repeat (4) @(posedge clk);
        check("drop_mem_hw4", 32'(u_mem.mem[4]), 32'h00005A5A);
        check("drop_mem_hw5", 32'(u_mem.mem[5]), 32'h0000A5A5);

        @(posedge clk); #1;
        bus.wr_en = 1'b1; bus.address = 32'd1036; bus.write_data = 32'h11112222;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; bus.wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", 32'(dut.state), 32'(IDLE));
        check("abort_we_n", 32'(bus.sram_we_n), 32'd1);
        check("abort_oe", 32'(bus.sram_dq_oe), 32'd0);
        check("abort_read_data", bus.read_data, 32'd0);
        we_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.sram_we_n !== 1'b1) we_ok = 1'b0;
        end
        check("abort_no_strobe", 32'(we_ok), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
